// File: rtl/l2_word_responder.sv
// l2_word_responder: backing-memory responder on the L2 side of the
// dcache<->L2 word interface. Serves one word per transaction (LOAD or
// STORE) with a fixed request-accept to req_fulfilled latency of LATENCY.
// req_type encoding: 2'd0 = LOAD, 2'd1 = STORE, any other value = LOAD.
// Optional feature macro: L2_ACCESS_COUNTERS_EN adds saturating
// load_count/store_count outputs.
module l2_word_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [1:0]      req_type,
  input  logic [XLEN-1:0] req_address,
  input  logic [XLEN-1:0] req_word_to_store,
  output logic [XLEN-1:0] fetched_word,
  output logic            req_fulfilled,
`ifdef L2_ACCESS_COUNTERS_EN
  output logic [31:0]     load_count,
  output logic [31:0]     store_count,
`endif
  output logic            busy
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] OP_STORE = 2'd1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  logic [XLEN-1:0]  mem [MEM_WORDS];
  logic [1:0]       state;
  logic [7:0]       cnt;
  logic             cap_store;
  logic [IDX_W-1:0] cap_idx;
  logic [XLEN-1:0]  cap_data;
  logic [IDX_W-1:0] req_idx;

  // Byte-offset bits and bits above the index are deliberately dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_address[XLEN-1:IDX_W+2], req_address[1:0]};

  // Word index taken straight from the request address.
  assign req_idx = req_address[IDX_W+1:2];

  // A request is in flight from the cycle after accept through RESPOND.
  assign busy = (state != S_IDLE);

  // Control FSM: capture in IDLE, count down in WAIT, pulse and read on entry to RESPOND.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      req_fulfilled <= 1'b0;
      fetched_word  <= '0;
    end else begin
      req_fulfilled <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_store <= (req_type == OP_STORE);
            cap_idx   <= req_idx;
            cap_data  <= req_word_to_store;
            if (LATENCY == 1) begin
              // Single-cycle latency skips WAIT, so the read uses the live address.
              state         <= S_RESPOND;
              req_fulfilled <= 1'b1;
              if (req_type != OP_STORE) begin
                fetched_word <= mem[req_idx];
              end
            end else begin
              cnt   <= CNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state         <= S_RESPOND;
            req_fulfilled <= 1'b1;
            if (!cap_store) begin
              fetched_word <= mem[cap_idx];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_RESPOND: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Store commits at the end of RESPOND; reset in that cycle suppresses it.
  always_ff @(posedge clk) begin
    if (!reset && state == S_RESPOND && cap_store) begin
      mem[cap_idx] <= cap_data;
    end
  end

`ifdef L2_ACCESS_COUNTERS_EN
  // Saturating per-type access counters, bumped in the RESPOND cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (state == S_RESPOND) begin
      if (cap_store) begin
        if (store_count != '1) store_count <= store_count + 32'd1;
      end else begin
        if (load_count != '1) load_count <= load_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_word_responder.sv
// Self-checking bench for l2_word_responder: one instance at LATENCY=4 and
// one at LATENCY=1, both checked against a word-array reference model.
module tb_l2_word_responder;

  logic        clk;
  logic        reset;

  logic        a_valid, b_valid;
  logic [1:0]  a_type, b_type;
  logic [31:0] a_addr, b_addr, a_data, b_data;
  logic [31:0] a_fw, b_fw;
  logic        a_ful, b_ful, a_busy, b_busy;
`ifdef L2_ACCESS_COUNTERS_EN
  logic [31:0] a_lc, a_sc, b_lc, b_sc;
`endif

  int checks;
  int failures;
  int cyc;

  logic [31:0] model [2][1024];
  logic [31:0] last_fw [2];
  int unsigned exp_loads [2];
  int unsigned exp_stores [2];

  l2_word_responder #(.XLEN(32), .MEM_WORDS(1024), .LATENCY(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_type(a_type),
    .req_address(a_addr), .req_word_to_store(a_data), .fetched_word(a_fw),
    .req_fulfilled(a_ful),
`ifdef L2_ACCESS_COUNTERS_EN
    .load_count(a_lc), .store_count(a_sc),
`endif
    .busy(a_busy)
  );

  l2_word_responder #(.XLEN(32), .MEM_WORDS(1024), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_type(b_type),
    .req_address(b_addr), .req_word_to_store(b_data), .fetched_word(b_fw),
    .req_fulfilled(b_ful),
`ifdef L2_ACCESS_COUNTERS_EN
    .load_count(b_lc), .store_count(b_sc),
`endif
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input int which);
`ifdef L2_ACCESS_COUNTERS_EN
    chk("load_count", which ? b_lc : a_lc, exp_loads[which]);
    chk("store_count", which ? b_sc : a_sc, exp_stores[which]);
`endif
  endtask

  // One transaction, entered and left at a negedge with the DUT idle.
  task automatic xact(input int which, input logic [1:0] t, input logic [31:0] addr,
                      input logic [31:0] data, input bit scramble);
    int lat;
    int idx;
    bit is_store;
    lat = which ? 1 : 4;
    idx = int'((addr / 4) % 1024);
    is_store = (t == 2'd1);
    if (which == 0) begin
      a_valid = 1'b1; a_type = t; a_addr = addr; a_data = data;
    end else begin
      b_valid = 1'b1; b_type = t; b_addr = addr; b_data = data;
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("busy_inflight", {31'd0, which ? b_busy : a_busy}, 32'd1);
      chk("fulfilled_timing", {31'd0, which ? b_ful : a_ful}, (k == lat) ? 32'd1 : 32'd0);
      if (k == lat) begin
        if (!is_store) last_fw[which] = model[which][idx];
        chk(is_store ? "fetched_hold_store" : "load_data", which ? b_fw : a_fw, last_fw[which]);
      end
      if (scramble && k < lat) begin
        if (which == 0) begin
          a_valid = 1'($urandom_range(0, 1)); a_addr = $urandom; a_data = $urandom;
          a_type = 2'($urandom_range(0, 3));
        end else begin
          b_valid = 1'($urandom_range(0, 1)); b_addr = $urandom; b_data = $urandom;
          b_type = 2'($urandom_range(0, 3));
        end
      end
    end
    if (is_store) begin
      model[which][idx] = data;
      exp_stores[which]++;
    end else begin
      exp_loads[which]++;
    end
    @(negedge clk);
    chk("busy_after", {31'd0, which ? b_busy : a_busy}, 32'd0);
    chk("fulfilled_after", {31'd0, which ? b_ful : a_ful}, 32'd0);
    chk("fetched_hold", which ? b_fw : a_fw, last_fw[which]);
    check_counts(which);
    if (which == 0) a_valid = 1'b0; else b_valid = 1'b0;
  endtask

  initial begin
    int t0;
    logic [31:0] addr;
    checks = 0; failures = 0; cyc = 0;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 1024; i++) model[w][i] = '0;
      last_fw[w] = '0; exp_loads[w] = 0; exp_stores[w] = 0;
    end
    a_valid = 0; a_type = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_type = 0; b_addr = 0; b_data = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_fw_a", a_fw, 32'd0);
    chk("reset_ful_a", {31'd0, a_ful}, 32'd0);
    chk("reset_busy_a", {31'd0, a_busy}, 32'd0);
    chk("reset_fw_b", b_fw, 32'd0);
    chk("reset_busy_b", {31'd0, b_busy}, 32'd0);
    check_counts(0);
    reset = 1'b0;
    @(negedge clk);

    // Basic load/store, sub-word offset and aliasing
    xact(0, 2'd1, 32'h14, 32'hDEAD_BEEF, 0);
    xact(0, 2'd0, 32'h14, 32'h0, 0);
    xact(0, 2'd1, 32'h20, 32'h1234_5678, 0);
    xact(0, 2'd0, 32'h20, 32'h0, 0);
    xact(0, 2'd0, 32'h23, 32'h0, 0);
    xact(0, 2'd1, 32'h0000_1004, 32'hA5A5_A5A5, 0);
    xact(0, 2'd0, 32'h0000_0004, 32'h0, 0);
    xact(0, 2'd3, 32'h14, 32'h0, 0);

    // Reset while a store sits in WAIT: nothing commits
    xact(0, 2'd1, 32'h40, 32'h0, 0);
    a_valid = 1'b1; a_type = 2'd1; a_addr = 32'h40; a_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("busy_pre_reset", {31'd0, a_busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ful_after_reset", {31'd0, a_ful}, 32'd0);
    chk("busy_after_reset", {31'd0, a_busy}, 32'd0);
    chk("fw_after_reset", a_fw, 32'd0);
    last_fw[0] = '0; last_fw[1] = '0;
    exp_loads[0] = 0; exp_stores[0] = 0; exp_loads[1] = 0; exp_stores[1] = 0;
    check_counts(0);
    reset = 1'b0; a_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_ful_post_reset", {31'd0, a_ful}, 32'd0);
    end
    xact(0, 2'd0, 32'h40, 32'h0, 0);

    // Inputs disturbed mid-flight: captured request still completes on time
    xact(0, 2'd0, 32'h14, 32'h0, 1);
    xact(0, 2'd1, 32'h48, 32'hCAFE_F00D, 1);
    xact(0, 2'd0, 32'h48, 32'h0, 0);

    // Randomised traffic over 16 words with aliasing and odd byte offsets
    for (int i = 0; i < 16; i++) begin
      addr = ($urandom & 32'hFFFF_F003) | (32'(i) << 2);
      xact(0, 2'd1, addr, $urandom, 0);
    end
    for (int i = 0; i < 40; i++) begin
      addr = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      xact(0, 2'($urandom_range(0, 3)), addr, $urandom, bit'($urandom_range(0, 1)));
    end

    // LATENCY=1: eight-word fill, back-to-back, 16 cycles, in order
    for (int i = 0; i < 8; i++) xact(1, 2'd1, 32'h100 + 32'(i * 4), $urandom, 0);
    t0 = cyc;
    for (int i = 0; i < 8; i++) xact(1, 2'd0, 32'h100 + 32'(i * 4), 32'h0, 0);
    chk("fill8_cycles", 32'(cyc - t0), 32'd16);
    for (int i = 0; i < 10; i++) begin
      addr = ($urandom & 32'hFFFF_F003) | (32'(64 + $urandom_range(0, 7)) << 2);
      xact(1, 2'($urandom_range(0, 3)), addr, $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
